// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for three bus masters with registered one-hot grants,
// an owner index for the bus muxes, and a tenure limit against starvation.
module bus_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       m_req,
    output logic [2:0]       m_grant,
    output logic [1:0]       m_sel,
    output logic             bus_busy,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_r, state_s;
    logic [2:0]       grant_r, grant_s;
    logic [1:0]       sel_r, sel_s;
    logic [1:0]       last_r, last_s;
    logic [CNT_W-1:0] hold_r, hold_s;
    logic             busy_r, busy_s;
    logic [2:0]       pick_any_s;
    logic [2:0]       pick_oth_s;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Returns {found, index}; skip_last drops the previous owner from the search.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last,
                                           input logic skip_last);
        logic [1:0] c1;
        logic [1:0] c2;
        logic [2:0] res;
        c1 = rr_next(last);
        c2 = rr_next(c1);
        if (req[c1]) begin
            res = {1'b1, c1};
        end else if (req[c2]) begin
            res = {1'b1, c2};
        end else if (!skip_last && req[last]) begin
            res = {1'b1, last};
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    assign pick_any_s = rr_pick(m_req, last_r, 1'b0);
    assign pick_oth_s = rr_pick(m_req, last_r, 1'b1);

    // Next-state arbitration: grant, tenure, handover and preemption.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        sel_s   = sel_r;
        last_s  = last_r;
        hold_s  = hold_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s[2]) begin
                    state_s = ST_OWN;
                    grant_s = to_onehot(pick_any_s[1:0]);
                    sel_s   = pick_any_s[1:0];
                    last_s  = pick_any_s[1:0];
                    hold_s  = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                    grant_s = 3'b000;
                    sel_s   = 2'd0;
                    hold_s  = {CNT_W{1'b0}};
                end
            end
            ST_OWN: begin
                if (m_req[sel_r]) begin
                    if (hold_r < HOLD_LAST) begin
                        hold_s = hold_r + HOLD_ONE;
                    end else if (pick_oth_s[2]) begin
                        grant_s = to_onehot(pick_oth_s[1:0]);
                        sel_s   = pick_oth_s[1:0];
                        last_s  = pick_oth_s[1:0];
                        hold_s  = {CNT_W{1'b0}};
                    end else begin
                        hold_s = HOLD_LAST;
                    end
                end else if (pick_any_s[2]) begin
                    // Owner released; its own req is low so it cannot win again here.
                    grant_s = to_onehot(pick_any_s[1:0]);
                    sel_s   = pick_any_s[1:0];
                    last_s  = pick_any_s[1:0];
                    hold_s  = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                    grant_s = 3'b000;
                    sel_s   = 2'd0;
                    hold_s  = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 3'b000;
                sel_s   = 2'd0;
                last_s  = 2'd2;
                hold_s  = {CNT_W{1'b0}};
            end
        endcase
        busy_s = |grant_s;
    end

    // State and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            grant_r <= 3'b000;
            sel_r   <= 2'd0;
            last_r  <= 2'd2;
            hold_r  <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            sel_r   <= sel_s;
            last_r  <= last_s;
            hold_r  <= hold_s;
            busy_r  <= busy_s;
        end
    end

    assign m_grant  = grant_r;
    assign m_sel    = sel_r;
    assign bus_busy = busy_r;
    assign hold_cnt = hold_r;

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter for the shared system bus. Three masters contend for it: M0 is the external/testbench master, M1 is the DMAC, and M2 is reserved for a second bus master.
- Produces registered one-hot grants plus an owner index, which drives the bus address/data/control muxes.
- Enforces a maximum tenure so that a long DMAC transfer cannot starve the other masters.
- Sits between the master request lines and the bus mux/decoder, replacing fixed-priority selection.

Parameters:
MAX_HOLD, 16, maximum consecutive granted cycles before preemption, if another master is waiting (legal range 2..255)
CNT_W, 8, width of the tenure counter (must satisfy 2^CNT_W > MAX_HOLD)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
m_req  input  3  request per master, bit i = master i; level, held for the whole transfer
m_grant  output  3  one-hot grant, registered; all zero when bus idle
m_sel  output  2  index of current owner (0..2); 0 when idle, so M0 is the default mux path
bus_busy  output  1  high while any grant is asserted
hold_cnt  output  CNT_W  cycles the current owner has held the grant, minus 1; 0 when idle

Behaviour:
- Reset values (asynchronous, reset_n=0): m_grant=3'b000, m_sel=0, bus_busy=0, hold_cnt=0, state=IDLE, last_owner=2. With last_owner=2, the first arbitration favours M0.
- States:
  - IDLE: no grant.
  - OWN: exactly one grant bit set.
- Round-robin search order: last_owner+1, last_owner+2, last_owner (mod 3); pick the first master with its req bit high.
- IDLE -> OWN:
  - Taken on any edge where m_req != 0.
  - Grant to the search winner, visible the cycle after req is sampled (latency 1).
  - Load m_sel = winner, last_owner = winner, hold_cnt = 0.
- OWN, owner req high, hold_cnt < MAX_HOLD-1: stay; hold_cnt increments.
- OWN, owner req high, hold_cnt = MAX_HOLD-1:
  - If any other req is high: preempt. Grant moves to the next other requester in round-robin order (the owner is excluded) on that edge, and hold_cnt resets to 0.
  - If no other request: owner keeps the grant and hold_cnt saturates at MAX_HOLD-1 (no wrap).
- OWN, owner req low:
  - The grant drops on that edge.
  - If another req is high, the grant switches directly to the next requester in round-robin order (handover with no idle cycle) and hold_cnt=0.
  - Otherwise go to IDLE: m_grant=0, m_sel=0, hold_cnt=0, bus_busy=0.
- Grant never changes without a clock edge. At most one grant bit is high in any cycle, and m_sel always equals the index of the set bit (0 when none).
- Simultaneous requests from IDLE: resolved purely by round-robin order from last_owner; there is no fixed priority.
- A master that drops req and re-raises it while still owner is handled as a release followed by a new request; its relative priority is the lowest because last_owner equals its own index.
- Req from a non-owner while the bus is busy: held pending; no effect until release or preemption.
- Masters must not start a bus access until they see their grant bit high. A preempted master sees its grant low on the next cycle and must re-request.
- Reset asserted mid-tenure: the grant is removed immediately (asynchronously) and all state returns to the reset values.

Test Plan:
1. Reset, then m_req=3'b010 for 5 cycles, then 0 -> m_grant=3'b010 from cycle 1 through cycle 5, m_sel=1, hold_cnt 0..4; returns to idle with m_grant=0, m_sel=0.
2. From reset, m_req=3'b111 held, MAX_HOLD=4 -> grants rotate M0,M1,M2,M0, each lasting exactly 4 cycles; consecutive grants change on adjacent edges with no idle gap.
3. M1 holds req 20 cycles alone, MAX_HOLD=16 -> M1 granted the whole time; hold_cnt saturates at 15; never preempted.
4. M1 owner at hold_cnt=15, M0 raises req -> next edge m_grant=3'b001, m_sel=0, hold_cnt=0; M1 (still requesting) is regranted after M0 releases.
5. M0 owns the bus; M2 and M1 both request; M0 drops req -> next grant goes to M1 (round-robin from last_owner=0), then M2.
6. reset_n pulsed low mid-grant, asynchronous to clk -> m_grant=0, bus_busy=0 before the next edge. After release with m_req=3'b110, the first grant is M1.
